// File: rtl/alu_pkg.sv
// Shared constants, FSM state type and decoded-issue payload for the ALU issue controller.
// ALU_ISSUE_M_EN (optional define) adds the funct7=0000001 multiply/divide encodings.
package alu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [3:0] ALU_SEL_NONE = 4'b0000;
  localparam logic [3:0] ALU_SEL_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SEL_AND  = 4'b0010;
  localparam logic [3:0] ALU_SEL_OR   = 4'b0011;
  localparam logic [3:0] ALU_SEL_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SEL_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SEL_SRA  = 4'b0110;
  localparam logic [3:0] ALU_SEL_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SEL_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SEL_DIV  = 4'b1001;
  localparam logic [3:0] ALU_SEL_REM  = 4'b1010;
  localparam logic [3:0] ALU_SEL_MUL  = 4'b1011;
  localparam logic [3:0] ALU_SEL_MULH = 4'b1100;
  localparam logic [3:0] ALU_SEL_SUB  = 4'b1101;
  localparam logic [3:0] ALU_SEL_BSEL = 4'b1110;
  localparam logic [3:0] ALU_SEL_SLTU = 4'b1111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Everything the controller needs to issue (or bypass) one instruction.
  typedef struct packed {
    logic [3:0]      sel;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      rd;
    logic            illegal;
    logic            bypass;
    logic [XLEN-1:0] byp_data;
  } dec_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32 decode into ALU select/operands, plus the ALU-bypass result path.
// ALU_ISSUE_M_EN enables MUL/MULH/DIV/REM (divide-by-zero results are produced here).
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output dec_t        dec
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       ill;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  always_comb begin
    dec    = '0;
    dec.rd = instr[11:7];
    ill    = 1'b1;
    case (opc)
      OPC_OP: begin
        dec.a = rs1_data;
        dec.b = rs2_data;
        if (f7 == F7_BASE) begin
          ill = 1'b0;
          case (f3)
            F3_ADD:  dec.sel = ALU_SEL_ADD;
            F3_SLL:  dec.sel = ALU_SEL_SLL;
            F3_SLT:  dec.sel = ALU_SEL_SLT;
            F3_SLTU: dec.sel = ALU_SEL_SLTU;
            F3_XOR:  dec.sel = ALU_SEL_XOR;
            F3_SR:   dec.sel = ALU_SEL_SRL;
            F3_OR:   dec.sel = ALU_SEL_OR;
            default: dec.sel = ALU_SEL_AND;
          endcase
        end else if (f7 == F7_ALT) begin
          if (f3 == F3_ADD) begin
            dec.sel = ALU_SEL_SUB;
            ill     = 1'b0;
          end else if (f3 == F3_SR) begin
            dec.sel = ALU_SEL_SRA;
            ill     = 1'b0;
          end
        end
`ifdef ALU_ISSUE_M_EN
        else if (f7 == F7_MULDIV) begin
          case (f3)
            3'b000: begin dec.sel = ALU_SEL_MUL;  ill = 1'b0; end
            3'b001: begin dec.sel = ALU_SEL_MULH; ill = 1'b0; end
            3'b100: begin
              dec.sel = ALU_SEL_DIV;
              ill     = 1'b0;
              if (rs2_data == 32'd0) begin
                dec.bypass   = 1'b1;
                dec.byp_data = 32'hFFFF_FFFF;
              end
            end
            3'b110: begin
              dec.sel = ALU_SEL_REM;
              ill     = 1'b0;
              if (rs2_data == 32'd0) begin
                dec.bypass   = 1'b1;
                dec.byp_data = rs1_data;
              end
            end
            default: ill = 1'b1;
          endcase
        end
`endif
      end
      OPC_OP_IMM: begin
        dec.a = rs1_data;
        dec.b = {{20{instr[31]}}, instr[31:20]};
        ill   = 1'b0;
        case (f3)
          F3_ADD:  dec.sel = ALU_SEL_ADD;
          F3_SLT:  dec.sel = ALU_SEL_SLT;
          F3_SLTU: dec.sel = ALU_SEL_SLTU;
          F3_XOR:  dec.sel = ALU_SEL_XOR;
          F3_OR:   dec.sel = ALU_SEL_OR;
          F3_AND:  dec.sel = ALU_SEL_AND;
          F3_SLL: begin
            dec.sel = ALU_SEL_SLL;
            dec.b   = {27'd0, instr[24:20]};
            ill     = (f7 != F7_BASE);
          end
          default: begin
            dec.sel = (f7 == F7_ALT) ? ALU_SEL_SRA : ALU_SEL_SRL;
            dec.b   = {27'd0, instr[24:20]};
            ill     = (f7 != F7_BASE) && (f7 != F7_ALT);
          end
        endcase
      end
      OPC_LUI: begin
        dec.sel = ALU_SEL_BSEL;
        dec.b   = {instr[31:12], 12'd0};
        ill     = 1'b0;
      end
      default: ill = 1'b1;
    endcase

    // Illegal instructions never reach the ALU; they complete through the bypass with zero data.
    if (ill) begin
      dec.sel      = ALU_SEL_NONE;
      dec.a        = '0;
      dec.b        = '0;
      dec.illegal  = 1'b1;
      dec.bypass   = 1'b1;
      dec.byp_data = '0;
    end else if (dec.bypass) begin
      dec.sel = ALU_SEL_NONE;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: handshake, decode, registered ALU drive, latency wait and writeback hold.
// ALU_ISSUE_M_EN (optional define, consumed by alu_decode) enables the M-extension subset.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [3:0]  alu_sel,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_we,
  output logic        wb_illegal
);

  localparam int unsigned CNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

  state_t             state, next_state;
  dec_t               dec;
  logic [CNT_W-1:0]   cnt;
  logic [4:0]         rd_q;
  logic               ill_q;
  logic               byp_q;
  logic [31:0]        byp_data_q;
  logic               accept;

  alu_decode u_decode (
    .instr    (instr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .dec      (dec)
  );

  assign accept = in_valid && in_ready;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (accept)          next_state = ST_WAIT;
      ST_WAIT: if (cnt == '0)       next_state = ST_RESP;
      ST_RESP: if (wb_ready)        next_state = ST_IDLE;
      default:                      next_state = ST_IDLE;
    endcase
  end

  // Bypassed ops (illegal, divide-by-zero) spend a single WAIT cycle so wb_valid lands at N+1.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      in_ready   <= 1'b0;
      alu_sel    <= ALU_SEL_NONE;
      alu_a      <= '0;
      alu_b      <= '0;
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_rd      <= '0;
      wb_we      <= 1'b0;
      wb_illegal <= 1'b0;
      cnt        <= '0;
      rd_q       <= '0;
      ill_q      <= 1'b0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      in_ready <= (next_state == ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rd_q       <= dec.rd;
            ill_q      <= dec.illegal;
            byp_q      <= dec.bypass;
            byp_data_q <= dec.byp_data;
            if (dec.bypass) begin
              alu_sel <= ALU_SEL_NONE;
              cnt     <= '0;
            end else begin
              alu_sel <= dec.sel;
              alu_a   <= dec.a;
              alu_b   <= dec.b;
              cnt     <= CNT_W'(ALU_LAT);
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            wb_valid   <= 1'b1;
            wb_data    <= byp_q ? byp_data_q : alu_result;
            wb_rd      <= rd_q;
            wb_illegal <= ill_q;
            wb_we      <= !ill_q && (rd_q != 5'd0);
            alu_sel    <= ALU_SEL_NONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RESP: if (wb_ready) wb_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
